// File: rtl/wf_issue_arbiter.sv
// rtl/wf_issue_arbiter.sv - round-robin wavefront issue arbiter with valid/ack handshake
module wf_issue_arbiter #(
  parameter int WF_PER_CU    = 40,
  parameter int WF_ID_LENGTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WF_PER_CU-1:0]    valid_entry,
  input  logic [WF_PER_CU-1:0]    wf_ready,
  input  logic                    f_salu_branch_en,
  input  logic                    f_salu_branch_taken,
  input  logic [WF_ID_LENGTH-1:0] f_salu_branch_wfid,
  input  logic                    issue_ack,
  output logic                    issued_valid,
  output logic [WF_ID_LENGTH-1:0] issued_wfid,
  output logic [WF_ID_LENGTH-1:0] rr_ptr
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [WF_PER_CU-1:0]    ONE_WF  = {{(WF_PER_CU-1){1'b0}}, 1'b1};
  localparam logic [WF_ID_LENGTH-1:0] LAST_WF = WF_ID_LENGTH'(WF_PER_CU - 1);

  state_t                    state_q, state_d;
  logic [WF_ID_LENGTH-1:0]   wfid_q, wfid_d;
  logic [WF_ID_LENGTH-1:0]   ptr_q, ptr_d;

  logic                      branch_kill;
  logic [WF_PER_CU-1:0]      kill;
  logic [WF_PER_CU-1:0]      held;
  logic [WF_PER_CU-1:0]      req;
  logic                      kill_issued;
  logic [WF_ID_LENGTH-1:0]   next_ptr;
  logic [WF_ID_LENGTH-1:0]   sel_base;
  logic                      sel_found;
  logic [WF_ID_LENGTH-1:0]   sel_wfid;
  int                        idx;

  assign branch_kill = f_salu_branch_en & f_salu_branch_taken;
  assign kill        = branch_kill ? (ONE_WF << f_salu_branch_wfid) : '0;
  assign held        = (state_q == PRESENT) ? (ONE_WF << wfid_q) : '0;
  assign req         = valid_entry & wf_ready & ~kill & ~held;
  assign kill_issued = branch_kill & (f_salu_branch_wfid == wfid_q);
  assign next_ptr    = (wfid_q == LAST_WF) ? '0 : wfid_q + WF_ID_LENGTH'(1);

  // An acked grant advances priority in the same cycle the next winner is chosen
  assign sel_base = ((state_q == PRESENT) && issue_ack) ? next_ptr : ptr_q;

  always_comb begin
    sel_found = 1'b0;
    sel_wfid  = '0;
    idx       = 0;
    for (int k = 0; k < WF_PER_CU; k++) begin
      idx = int'(sel_base) + k;
      if (idx >= WF_PER_CU) begin
        idx = idx - WF_PER_CU;
      end
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_wfid  = WF_ID_LENGTH'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wfid_d  = wfid_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = PRESENT;
          wfid_d  = sel_wfid;
        end
      end
      PRESENT: begin
        // Ack takes precedence over a same-cycle branch squash
        if (issue_ack) begin
          ptr_d = next_ptr;
          if (sel_found) begin
            wfid_d = sel_wfid;
          end else begin
            state_d = IDLE;
          end
        end else if (kill_issued) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wfid_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      wfid_q  <= wfid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign issued_valid = (state_q == PRESENT);
  assign issued_wfid  = wfid_q;
  assign rr_ptr       = ptr_q;

endmodule

// File: tb/tb_wf_issue_arbiter.sv
// tb/tb_wf_issue_arbiter.sv - scoreboard bench for wf_issue_arbiter
module tb_wf_issue_arbiter;

  localparam int WF_PER_CU    = 40;
  localparam int WF_ID_LENGTH = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [WF_PER_CU-1:0]    valid_entry;
  logic [WF_PER_CU-1:0]    wf_ready;
  logic                    f_salu_branch_en;
  logic                    f_salu_branch_taken;
  logic [WF_ID_LENGTH-1:0] f_salu_branch_wfid;
  logic                    issue_ack;
  logic                    issued_valid;
  logic [WF_ID_LENGTH-1:0] issued_wfid;
  logic [WF_ID_LENGTH-1:0] rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;
  int sb_q[$];
  bit tracker_en;

  wf_issue_arbiter #(
    .WF_PER_CU    (WF_PER_CU),
    .WF_ID_LENGTH (WF_ID_LENGTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_entry         (valid_entry),
    .wf_ready            (wf_ready),
    .f_salu_branch_en    (f_salu_branch_en),
    .f_salu_branch_taken (f_salu_branch_taken),
    .f_salu_branch_wfid  (f_salu_branch_wfid),
    .issue_ack           (issue_ack),
    .issued_valid        (issued_valid),
    .issued_wfid         (issued_wfid),
    .rr_ptr              (rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Acked grants retire against the scoreboard on the falling edge; the tracker
  // clear of the consumed entry is modelled here as well.
  task automatic tick();
    logic [31:0] exp;
    @(negedge clk);
    if (issued_valid && issue_ack) begin
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
      check_eq("sb_grant", {26'b0, issued_wfid}, exp);
      if (tracker_en) valid_entry[issued_wfid] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                 = 1'b0;
    valid_entry         = '0;
    wf_ready            = '1;
    f_salu_branch_en    = 1'b0;
    f_salu_branch_taken = 1'b0;
    f_salu_branch_wfid  = '0;
    issue_ack           = 1'b0;
    tracker_en          = 1'b1;

    tick();
    tick();
    check_eq("rst_valid", {31'b0, issued_valid}, 0);
    check_eq("rst_wfid", {26'b0, issued_wfid}, 0);
    check_eq("rst_ptr", {26'b0, rr_ptr}, 0);
    rst = 1'b1;

    // Two requesters, ack tied high
    valid_entry[3] = 1'b1;
    valid_entry[7] = 1'b1;
    issue_ack = 1'b1;
    sb_q.push_back(3);
    sb_q.push_back(7);
    tick();
    check_eq("t1_valid_c1", {31'b0, issued_valid}, 1);
    check_eq("t1_wfid_c1", {26'b0, issued_wfid}, 3);
    tick();
    check_eq("t1_wfid_c2", {26'b0, issued_wfid}, 7);
    tick();
    check_eq("t1_idle", {31'b0, issued_valid}, 0);
    check_eq("t1_ptr", {26'b0, rr_ptr}, 8);

    // Wrap-around from rr_ptr=8
    valid_entry[2]  = 1'b1;
    valid_entry[39] = 1'b1;
    sb_q.push_back(39);
    sb_q.push_back(2);
    tick();
    check_eq("t2_wfid_39", {26'b0, issued_wfid}, 39);
    tick();
    check_eq("t2_wfid_2", {26'b0, issued_wfid}, 2);
    tick();
    check_eq("t2_idle", {31'b0, issued_valid}, 0);
    check_eq("t2_ptr", {26'b0, rr_ptr}, 3);

    // Hold without ack; wf 9 valid but never ready
    issue_ack = 1'b0;
    valid_entry = '0;
    valid_entry[5] = 1'b1;
    valid_entry[9] = 1'b1;
    wf_ready = '0;
    wf_ready[5] = 1'b1;
    sb_q.push_back(5);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_hold_valid", {31'b0, issued_valid}, 1);
      check_eq("t3_hold_wfid", {26'b0, issued_wfid}, 5);
      if (i < 3) tick();
    end
    issue_ack = 1'b1;
    tick();
    check_eq("t3_idle", {31'b0, issued_valid}, 0);
    check_eq("t3_ptr", {26'b0, rr_ptr}, 6);
    issue_ack = 1'b0;
    valid_entry = '0;
    wf_ready = '1;

    // Branch squash, then squash coinciding with ack
    valid_entry[12] = 1'b1;
    tick();
    check_eq("t4_wfid", {26'b0, issued_wfid}, 12);
    f_salu_branch_en    = 1'b1;
    f_salu_branch_taken = 1'b1;
    f_salu_branch_wfid  = 6'd12;
    tick();
    check_eq("t4_squash_valid", {31'b0, issued_valid}, 0);
    check_eq("t4_squash_ptr", {26'b0, rr_ptr}, 6);
    f_salu_branch_en = 1'b0;
    tick();
    check_eq("t4_regrant_valid", {31'b0, issued_valid}, 1);
    check_eq("t4_regrant_wfid", {26'b0, issued_wfid}, 12);
    sb_q.push_back(12);
    issue_ack        = 1'b1;
    f_salu_branch_en = 1'b1;
    tick();
    check_eq("t4_ackwin_valid", {31'b0, issued_valid}, 0);
    check_eq("t4_ackwin_ptr", {26'b0, rr_ptr}, 13);
    f_salu_branch_en    = 1'b0;
    f_salu_branch_taken = 1'b0;
    issue_ack = 1'b0;

    rst = 1'b0;
    tick();
    check_eq("rst2_ptr", {26'b0, rr_ptr}, 0);
    rst = 1'b1;
    tick();

    // All wavefronts requesting continuously
    tracker_en  = 1'b0;
    valid_entry = '1;
    issue_ack   = 1'b1;
    for (int i = 0; i < WF_PER_CU; i++) sb_q.push_back(i);
    sb_q.push_back(0);
    for (int c = 0; c < 60 && sb_q.size() > 0; c++) tick();
    issue_ack   = 1'b0;
    valid_entry = '0;
    check_eq("t5_drained", sb_q.size(), 0);
    check_eq("t5_ptr", {26'b0, rr_ptr}, 1);

    // Asynchronous reset while presenting wf 20
    tracker_en = 1'b1;
    valid_entry[20] = 1'b1;
    issue_ack = 1'b1;
    sb_q.push_back(1);
    tick();
    issue_ack = 1'b0;
    check_eq("t6_wfid", {26'b0, issued_wfid}, 20);
    check_eq("t6_ptr", {26'b0, rr_ptr}, 2);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_async_valid", {31'b0, issued_valid}, 0);
    check_eq("t6_async_ptr", {26'b0, rr_ptr}, 0);
    check_eq("t6_async_wfid", {26'b0, issued_wfid}, 0);
    tick();
    check_eq("t6_in_rst_valid", {31'b0, issued_valid}, 0);
    rst = 1'b1;
    #1;
    check_eq("t6_release_valid", {31'b0, issued_valid}, 0);
    @(posedge clk);
    #1;
    check_eq("t6_regrant_wfid", {26'b0, issued_wfid}, 20);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wf_issue_arbiter.md
Name: wf_issue_arbiter

Overview:
- Round-robin scheduler sitting between the issue-stage per-wavefront valid-entry bitmap and the functional-unit dispatch path.
- Each cycle it selects one wavefront that has a valid decoded instruction and whose operands are ready.
- It presents the chosen wfid with a valid/ack handshake to the downstream FU.
- Its issue output drives the issue-clear inputs of the valid-entry tracker.

Parameters:
- WF_PER_CU, 40, number of wavefront slots (bitmap width).
- WF_ID_LENGTH, 6, wavefront ID width; must satisfy 2^WF_ID_LENGTH >= WF_PER_CU.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-low: rst=0 resets immediately, independent of clk.
- valid_entry  input  WF_PER_CU  per-wf valid decoded instruction, bit i = wfid i.
- wf_ready  input  WF_PER_CU  per-wf operand/scoreboard ready.
- f_salu_branch_en  input  1  SALU branch result valid.
- f_salu_branch_taken  input  1  branch taken qualifier.
- f_salu_branch_wfid  input  WF_ID_LENGTH  wf of branch result.
- issue_ack  input  1  downstream FU accepts the presented instruction this cycle.
- issued_valid  output  1  an instruction is presented.
- issued_wfid  output  WF_ID_LENGTH  wfid presented; stable while issued_valid=1 and not acked.
- rr_ptr  output  WF_ID_LENGTH  current highest-priority wfid (debug/verification visibility).

Behaviour:
- Reset (rst=0, asynchronous):
  - issued_valid=0, issued_wfid=0, rr_ptr=0, FSM=IDLE.
- Request vector: req[i] = valid_entry[i] & wf_ready[i] & ~kill[i] & ~held[i].
  - kill = one-hot decode of f_salu_branch_wfid, qualified by f_salu_branch_en & f_salu_branch_taken.
  - held = one-hot of issued_wfid when issued_valid=1.
- Selection:
  - Pick the first set req bit scanning upward from rr_ptr, wrapping from WF_PER_CU-1 to 0.
  - Indices >= WF_PER_CU never requested. Purely combinational, one-cycle result.
- FSM states: IDLE (issued_valid=0), PRESENT (issued_valid=1).
- IDLE:
  - If any req, register the selected wfid into issued_wfid, go to PRESENT.
  - Latency: request visible in cycle t -> issued_valid=1 in cycle t+1.
- PRESENT:
  - issued_wfid is held constant until one of:
    - (a) issue_ack=1: the grant completes.
      - rr_ptr <= issued_wfid+1, wrapping to 0 when issued_wfid = WF_PER_CU-1.
      - If any req (held excluded) exists, select again using the updated priority. The new wfid loads the same edge and the FSM stays in PRESENT (back-to-back, 1 issue/cycle).
      - Otherwise go to IDLE.
    - (b) Taken branch for issued_wfid with issue_ack=0: the grant is squashed.
      - Go to IDLE. rr_ptr unchanged.
      - No re-selection that cycle; earliest re-grant next cycle.
    - (c) Taken branch for issued_wfid with issue_ack=1 the same cycle: ack wins. Treat as (a); the instruction was consumed.
  - valid_entry[issued_wfid] dropping while presenting (external clear) does not retract the grant; only the branch kill does.
- rr_ptr changes only on acked grants; squashes and idle cycles never move it.
- Starvation freedom: a wavefront continuously requesting is granted within WF_PER_CU acked grants.
- Reset asserted mid-PRESENT:
  - Outputs clear asynchronously.
  - Nothing is presented until at least one clk edge after rst returns to 1.
- No X propagation: issued_wfid holds its last value when issued_valid=0 (value is don't-care to consumers).

Test Plan:
- Reset then valid_entry=wf_ready=bits{3,7} set, issue_ack tied 1 -> issued_wfid 3 at cycle 1, 7 at cycle 2, then issued_valid=0; rr_ptr=8.
- rr_ptr=8 (from previous test), request bits {2,39} -> grant 39 first, then 2 (wrap); rr_ptr ends at 3.
- Request wf 5 only, issue_ack=0 for 4 cycles -> issued_valid=1, issued_wfid=5 stable all 4 cycles; ack in cycle 5 -> issued_valid=0 next cycle.
- Presenting wf 12 with ack=0, branch_en=taken=1 and branch_wfid=12 -> issued_valid=0 next cycle, rr_ptr unchanged. Repeat with ack=1 the same cycle -> counted as issued, rr_ptr=13.
- All 40 bits requesting continuously, ack=1 -> grants 0,1,…,39,0 in strict order; no wf is skipped or repeated within 40 grants.
- Assert rst=0 between clock edges while presenting wf 20 -> issued_valid and rr_ptr read 0 before the next clk edge.
